// File: rtl/stage3_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// stage3_fetch_stage_if
//   Instruction-memory request/response bundle between the fetch stage and
//   the instruction bus.
//
//   imem_addr   fetch address (driven by the fetch stage)
//   imem_ren    read request  (driven by the fetch stage)
//   imem_busy   bus wait; the request is held while this is high
//   imem_rdata  returned instruction word
//   imem_fault  access fault for the current request
//
//   master : fetch stage side
//   slave  : memory / bus side
// ---------------------------------------------------------------------------
interface stage3_fetch_stage_if;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        imem_fault;

  modport master (
    output imem_addr,
    output imem_ren,
    input  imem_busy,
    input  imem_rdata,
    input  imem_fault
  );

  modport slave (
    input  imem_addr,
    input  imem_ren,
    output imem_busy,
    output imem_rdata,
    output imem_fault
  );
endinterface

// File: rtl/stage3_fetch_stage.sv
// ---------------------------------------------------------------------------
// stage3_fetch_stage
//   Instruction fetch stage: owns the fetch PC, issues requests on the
//   instruction bus, absorbs redirects that arrive while a bus transfer is
//   still in flight, and fills the IF/EX pipeline latch.
//
//   Optional build macro: STAGE3_FETCH_MISALIGN_CHECK_EN
//     defined   : a fetch PC with pc_f[1:0] != 0 is never sent to the bus; it
//                 completes immediately as a NOP tagged ex_mal_insn=1 and
//                 records its address in fault_addr_fetch.
//     undefined : the bus address is always word aligned and ex_mal_insn=0.
//
//   Ports
//     CLK, nRST                 clock (rising edge), async active-low reset
//     pc_en                     sequential / predicted PC advance permitted
//     npc_sel, resolved_pc      mem-stage redirect (mispredict / jump)
//     insert_priv_pc, priv_pc   trap / xRET redirect
//     rollback, rollback_pc     refetch redirect
//     if_ex_stall, if_ex_flush  IF/EX latch hold / squash
//     iren, suppress_iren       fetch enable / fetch inhibit
//     predict_taken/_target     branch predictor result for pc_f
//     imem (master modport)     instruction bus request / response
//     pc_f                      current fetch PC
//     i_mem_busy                fetch stall to the hazard unit
//     fault_addr_fetch          address of the last faulting fetch
//     ex_*                      IF/EX latch contents
// ---------------------------------------------------------------------------
module stage3_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        pc_en,
  input  logic                        npc_sel,
  input  logic [31:0]                 resolved_pc,
  input  logic                        insert_priv_pc,
  input  logic [31:0]                 priv_pc,
  input  logic                        rollback,
  input  logic [31:0]                 rollback_pc,
  input  logic                        if_ex_stall,
  input  logic                        if_ex_flush,
  input  logic                        iren,
  input  logic                        suppress_iren,
  input  logic                        predict_taken,
  input  logic [31:0]                 predict_target,
  stage3_fetch_stage_if.master        imem,
  output logic [31:0]                 pc_f,
  output logic                        i_mem_busy,
  output logic [31:0]                 fault_addr_fetch,
  output logic                        ex_valid,
  output logic [31:0]                 ex_pc,
  output logic [31:0]                 ex_pc4,
  output logic [31:0]                 ex_instr,
  output logic                        ex_pred_taken,
  output logic                        ex_fault_insn,
  output logic                        ex_mal_insn
);

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] req_addr, req_addr_nxt;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_want;
  logic        misaligned;
  logic [31:0] fetch_addr;
  logic        ren_w;
  logic [31:0] addr_w;
  logic        fetch_done;
  logic [31:0] pc_plus4;
  logic [31:0] pc_nxt;

  // Redirect sources, highest priority first.
  always_comb begin
    redirect    = insert_priv_pc | rollback | npc_sel;
    redirect_pc = resolved_pc;
    if (insert_priv_pc) begin
      redirect_pc = priv_pc;
    end else if (rollback) begin
      redirect_pc = rollback_pc;
    end
  end

  assign fetch_want = iren & ~suppress_iren;
  assign pc_plus4   = pc_f + 32'd4;

`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc_f[1:0] != 2'b00);
  assign fetch_addr = pc_f;
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {pc_f[31:2], 2'b00};
`endif

  // FSM next-state and bus outputs. DRAIN keeps the abandoned request on
  // the bus until the memory finishes it, so the bus never sees a request
  // withdrawn mid-transfer.
  always_comb begin
    state_nxt    = state;
    req_addr_nxt = req_addr;
    ren_w        = 1'b0;
    addr_w       = fetch_addr;
    fetch_done   = 1'b0;
    case (state)
      FETCH: begin
        ren_w = fetch_want & ~misaligned;
        // A misaligned PC completes without using the bus.
        if (misaligned) begin
          fetch_done = fetch_want & ~redirect;
        end else begin
          fetch_done = ren_w & ~imem.imem_busy & ~redirect;
        end
        if (redirect & ren_w & imem.imem_busy) begin
          state_nxt    = DRAIN;
          req_addr_nxt = fetch_addr;
        end
      end
      DRAIN: begin
        ren_w  = 1'b1;
        addr_w = req_addr;
        if (!imem.imem_busy) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  assign imem.imem_ren  = ren_w;
  assign imem.imem_addr = addr_w;
  assign i_mem_busy     = ren_w & (imem.imem_busy | (state == DRAIN));

  // Next PC: redirects win regardless of pc_en; otherwise advance only on a
  // completed fetch the hazard unit allows.
  always_comb begin
    pc_nxt = pc_f;
    if (redirect) begin
      pc_nxt = redirect_pc;
    end else if (pc_en & fetch_done) begin
      pc_nxt = predict_taken ? predict_target : pc_plus4;
    end
  end

  // ---- Fetch PC / FSM registers ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= FETCH;
      req_addr <= 32'h0000_0000;
      pc_f     <= RESET_PC;
    end else begin
      state    <= state_nxt;
      req_addr <= req_addr_nxt;
      pc_f     <= pc_nxt;
    end
  end

  // ---- Fault address capture ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fault_addr_fetch <= 32'h0000_0000;
    end else if (fetch_done & (misaligned | imem.imem_fault)) begin
      fault_addr_fetch <= pc_f;
    end
  end

  // ---- IF/EX latch ----
  // Flush clears only the valid bit; data fields keep their last value.
  // Responses returning while draining are never loaded.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid      <= 1'b0;
      ex_pc         <= 32'h0000_0000;
      ex_pc4        <= 32'h0000_0000;
      ex_instr      <= NOP_INSN;
      ex_pred_taken <= 1'b0;
      ex_fault_insn <= 1'b0;
    end else if (if_ex_flush) begin
      ex_valid <= 1'b0;
    end else if (!if_ex_stall) begin
      if (state == DRAIN) begin
        ex_valid <= 1'b0;
      end else begin
        ex_valid      <= fetch_done;
        ex_pc         <= pc_f;
        ex_pc4        <= pc_plus4;
        ex_instr      <= misaligned ? NOP_INSN : imem.imem_rdata;
        ex_pred_taken <= predict_taken;
        ex_fault_insn <= misaligned ? 1'b0 : imem.imem_fault;
      end
    end
  end

`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_mal_insn <= 1'b0;
    end else if (!if_ex_flush && !if_ex_stall && (state == FETCH)) begin
      ex_mal_insn <= misaligned;
    end
  end
`else
  assign ex_mal_insn = 1'b0;
`endif

endmodule

// File: tb/tb_stage3_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_stage3_fetch_stage
//   Directed scenarios followed by randomized traffic, all compared against
//   a transaction-level reference model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_stage3_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, npc_sel, insert_priv_pc, rollback;
  logic [31:0] resolved_pc, priv_pc, rollback_pc;
  logic        if_ex_stall, if_ex_flush, iren, suppress_iren;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic [31:0] pc_f, fault_addr_fetch, ex_pc, ex_pc4, ex_instr;
  logic        i_mem_busy, ex_valid, ex_pred_taken, ex_fault_insn, ex_mal_insn;

  stage3_fetch_stage_if imem ();

  stage3_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .pc_en            (pc_en),
    .npc_sel          (npc_sel),
    .resolved_pc      (resolved_pc),
    .insert_priv_pc   (insert_priv_pc),
    .priv_pc          (priv_pc),
    .rollback         (rollback),
    .rollback_pc      (rollback_pc),
    .if_ex_stall      (if_ex_stall),
    .if_ex_flush      (if_ex_flush),
    .iren             (iren),
    .suppress_iren    (suppress_iren),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .imem             (imem),
    .pc_f             (pc_f),
    .i_mem_busy       (i_mem_busy),
    .fault_addr_fetch (fault_addr_fetch),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_pc4           (ex_pc4),
    .ex_instr         (ex_instr),
    .ex_pred_taken    (ex_pred_taken),
    .ex_fault_insn    (ex_fault_insn),
    .ex_mal_insn      (ex_mal_insn)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- reference model state ----
  logic [31:0] m_pc, m_req, m_faddr;
  bit          m_drain;            // an abandoned request is still on the bus
  bit          m_vld, m_pt, m_fi, m_mi;
  logic [31:0] m_epc, m_epc4, m_instr;

  function automatic void model_reset();
    m_pc = RST_PC; m_req = '0; m_faddr = '0; m_drain = 0;
    m_vld = 0; m_pt = 0; m_fi = 0; m_mi = 0;
    m_epc = '0; m_epc4 = '0; m_instr = NOP;
  endfunction

  function automatic bit model_misaligned(input logic [31:0] pc);
`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_bus_addr(input logic [31:0] pc);
`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
    return pc;
`else
    return pc & 32'hFFFF_FFFC;
`endif
  endfunction

  // One clock cycle: check everything visible now, predict the next cycle,
  // clock the DUT and return at the following falling edge.
  task automatic step();
    bit          want, mis, ren, redir, done;
    logic [31:0] addr, tgt;
    #1;
    want = iren & ~suppress_iren;
    mis  = model_misaligned(m_pc);
    ren  = m_drain ? 1'b1 : (want & ~mis);
    addr = m_drain ? m_req : model_bus_addr(m_pc);
    chk("imem_ren", imem.imem_ren, ren);
    chk("imem_addr", imem.imem_addr, addr);
    chk("i_mem_busy", i_mem_busy, ren & (imem.imem_busy | m_drain));
    chk("pc_f", pc_f, m_pc);
    chk("ex_valid", ex_valid, m_vld);
    chk("ex_pc", ex_pc, m_epc);
    chk("ex_pc4", ex_pc4, m_epc4);
    chk("ex_instr", ex_instr, m_instr);
    chk("ex_pred_taken", ex_pred_taken, m_pt);
    chk("ex_fault_insn", ex_fault_insn, m_fi);
    chk("ex_mal_insn", ex_mal_insn, m_mi);
    chk("fault_addr", fault_addr_fetch, m_faddr);

    redir = insert_priv_pc | rollback | npc_sel;
    tgt   = insert_priv_pc ? priv_pc : (rollback ? rollback_pc : resolved_pc);
    done  = !m_drain && !redir && (mis ? want : (ren && !imem.imem_busy));

    @(posedge CLK);
    if (done && (mis || imem.imem_fault)) m_faddr = m_pc;
    if (if_ex_flush) m_vld = 0;
    else if (!if_ex_stall) begin
      if (m_drain) m_vld = 0;
      else begin
        m_vld = done; m_epc = m_pc; m_epc4 = m_pc + 32'd4;
        m_instr = mis ? NOP : imem.imem_rdata;
        m_pt = predict_taken; m_fi = mis ? 1'b0 : imem.imem_fault; m_mi = mis;
      end
    end
    if (m_drain) m_drain = imem.imem_busy;
    else if (redir && ren && imem.imem_busy) begin m_drain = 1; m_req = addr; end
    if (redir) m_pc = tgt;
    else if (pc_en && done) m_pc = predict_taken ? predict_target : m_pc + 32'd4;
    @(negedge CLK);
  endtask

  task automatic quiet_inputs();
    pc_en = 1; npc_sel = 0; insert_priv_pc = 0; rollback = 0;
    resolved_pc = '0; priv_pc = '0; rollback_pc = '0;
    if_ex_stall = 0; if_ex_flush = 0; iren = 1; suppress_iren = 0;
    predict_taken = 0; predict_target = '0;
    imem.imem_busy = 0; imem.imem_rdata = $urandom; imem.imem_fault = 0;
  endtask

  // Asynchronous reset applied mid-cycle, checked before any clock edge.
  task automatic do_reset();
    @(negedge CLK);
    #2 nRST = 0;
    model_reset();
    #1;
    chk("rst_pc_f", pc_f, RST_PC);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_instr", ex_instr, NOP);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_fault_addr", fault_addr_fetch, 32'h0);
    @(negedge CLK);
    nRST = 1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 15) != 0) t[1:0] = 2'b00;
    if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFFC;
    return t;
  endfunction

  logic [31:0] held;

  initial begin
    nRST = 1;
    quiet_inputs();
    do_reset();

    // Straight-line fetch after reset.
    quiet_inputs();
    #1 chk("seq_addr0", imem.imem_addr, 32'h8000_0000);
    step();
    chk("seq_addr1", imem.imem_addr, 32'h8000_0004);
    chk("seq_valid1", ex_valid, 1);
    chk("seq_expc1", ex_pc, 32'h8000_0000);
    step();
    chk("seq_addr2", imem.imem_addr, 32'h8000_0008);
    chk("seq_valid2", ex_valid, 1);
    step();

    // Redirect during a busy transfer: drain, drop the data, refetch.
    do_reset();
    quiet_inputs();
    step();
    imem.imem_busy = 1; npc_sel = 1; resolved_pc = 32'h0000_1000;
    #1 chk("drn_busy", i_mem_busy, 1);
    step();
    npc_sel = 0;
    #1 chk("drn_addr_held", imem.imem_addr, 32'h8000_0004);
    chk("drn_ren", imem.imem_ren, 1);
    chk("drn_pc", pc_f, 32'h0000_1000);
    step();
    imem.imem_busy = 0; imem.imem_rdata = 32'hDEAD_BEEF;
    #1 chk("drn_addr_last", imem.imem_addr, 32'h8000_0004);
    step();
    chk("drn_dropped", ex_valid, 0);
    chk("drn_next_addr", imem.imem_addr, 32'h0000_1000);
    step();

    // Reset in the middle of a drain abandons it.
    do_reset();
    quiet_inputs();
    step();
    imem.imem_busy = 1; npc_sel = 1; resolved_pc = 32'h0000_2000;
    step();
    npc_sel = 0; iren = 0;
    #1 chk("rstdrn_pre_ren", imem.imem_ren, 1);
    nRST = 0; model_reset();
    #1 chk("rstdrn_ren", imem.imem_ren, 0);
    @(negedge CLK);
    nRST = 1;
    step();

    // Redirect priority.
    quiet_inputs();
    insert_priv_pc = 1; rollback = 1; npc_sel = 1;
    priv_pc = 32'h0000_0200; rollback_pc = 32'h0000_0300; resolved_pc = 32'h0000_0400;
    step();
    chk("prio_pc", pc_f, 32'h0000_0200);
    quiet_inputs();
    rollback = 1; npc_sel = 1; rollback_pc = 32'h0000_0300; resolved_pc = 32'h0000_0400;
    step();
    chk("prio_rb_pc", pc_f, 32'h0000_0300);

    // Prediction and address wrap.
    quiet_inputs();
    predict_taken = 1; predict_target = 32'h0000_4000;
    step();
    chk("pred_pc", pc_f, 32'h0000_4000);
    quiet_inputs();
    npc_sel = 1; resolved_pc = 32'hFFFF_FFFC;
    step();
    quiet_inputs();
    step();
    chk("wrap_pc", pc_f, 32'h0000_0000);
    chk("wrap_pc4", ex_pc4, 32'h0000_0000);

    // Flush beats stall; stall alone holds the latch.
    quiet_inputs();
    imem.imem_rdata = 32'h1234_5678;
    step();
    held = m_instr;
    chk("stl_loaded", ex_instr, 32'h1234_5678);
    if_ex_flush = 1; if_ex_stall = 1; imem.imem_rdata = $urandom;
    step();
    chk("flush_valid", ex_valid, 0);
    if_ex_flush = 0;
    for (int i = 0; i < 3; i++) begin
      imem.imem_rdata = $urandom;
      step();
      chk("stall_instr", ex_instr, held);
    end

    // Fetch fault at 8000_0010.
    do_reset();
    quiet_inputs();
    repeat (4) step();
    #1 chk("flt_pc", pc_f, 32'h8000_0010);
    imem.imem_fault = 1;
    step();
    chk("flt_insn", ex_fault_insn, 1);
    chk("flt_addr", fault_addr_fetch, 32'h8000_0010);
    imem.imem_fault = 0;
    step();
    chk("flt_addr_hold", fault_addr_fetch, 32'h8000_0010);

`ifdef STAGE3_FETCH_MISALIGN_CHECK_EN
    // Misaligned fetch target.
    quiet_inputs();
    npc_sel = 1; resolved_pc = 32'h0000_1002;
    step();
    npc_sel = 0; pc_en = 0;
    #1 chk("mal_ren", imem.imem_ren, 0);
    step();
    chk("mal_flag", ex_mal_insn, 1);
    chk("mal_instr", ex_instr, NOP);
    chk("mal_valid", ex_valid, 1);
    chk("mal_addr", fault_addr_fetch, 32'h0000_1002);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      iren           = ($urandom_range(0, 9) != 0);
      suppress_iren  = ($urandom_range(0, 9) == 0);
      pc_en          = ($urandom_range(0, 4) != 0);
      npc_sel        = ($urandom_range(0, 9) == 0);
      rollback       = ($urandom_range(0, 19) == 0);
      insert_priv_pc = ($urandom_range(0, 24) == 0);
      resolved_pc    = rnd_tgt();
      rollback_pc    = rnd_tgt();
      priv_pc        = rnd_tgt();
      if_ex_stall    = ($urandom_range(0, 6) == 0);
      if_ex_flush    = ($urandom_range(0, 15) == 0);
      predict_taken  = ($urandom_range(0, 4) == 0);
      predict_target = rnd_tgt();
      imem.imem_busy  = ($urandom_range(0, 2) == 0);
      imem.imem_rdata = $urandom;
      imem.imem_fault = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
